// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-precision adder that reuses one 4-bit ripple slice, one nibble per clock,
// LSB nibble first, with valid/ready handshakes on both the operand and result sides.

module fa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int N_NIB = 4,
  parameter int CNT_W = 4,
  localparam int W = 4 * N_NIB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         co,
  output logic         ovf,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [W-1:0]     a_r, b_r;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       slice_s;
  logic             slice_co;

  fa4 fa4_inst (
    .a  (a_r[3:0]),
    .b  (b_r[3:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Handshake outputs are pure decodes of registered state.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            carry <= ci;
            cnt   <= '0;
            s     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_r   <= a_r >> 4;
          b_r   <= b_r >> 4;
          // New nibble enters at the top; after N_NIB shifts nibble k lands at [4k+3:4k].
          s     <= {slice_s, s[W-1:4]};
          carry <= slice_co;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(N_NIB - 1)) begin
            co    <= slice_co;
            ovf   <= (a_r[3] == b_r[3]) && (slice_s[3] != a_r[3]);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: expected results are queued at each accept and a monitor
// compares them whenever a result handshake happens.

module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, ci, out_valid, out_ready, co, ovf, busy;
  logic [15:0] a, b, s;
  logic        or_dir, or_rnd, rand_mode;

  typedef struct packed {logic [15:0] s; logic co; logic ovf;} res_t;
  res_t exp_q[$];

  int pass_cnt = 0, total = 0, sends = 0, accepts = 0;

  assign out_ready = rand_mode ? or_rnd : or_dir;

  nibble_serial_adder_ctrl #(.N_NIB(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    or_rnd = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: count accepts and check every result handshake against the queue.
  always @(negedge clk) begin
    res_t e;
    if (!rst && in_valid && in_ready) accepts++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got s=%h co=%b ovf=%b with nothing expected", s, co, ovf);
      end else begin
        e = exp_q.pop_front();
        chk("result", {13'b0, s, co, ovf}, {13'b0, e});
      end
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tci,
                      input logic [15:0] es, input logic eco, input logic eovf, input bit push);
    int n = 0;
    a = ta; b = tb_v; ci = tci; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin n++; @(negedge clk); end
    if (!in_ready) begin
      total++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
    end else begin
      if (push) exp_q.push_back('{es, eco, eovf});
      sends++;
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin n++; @(negedge clk); end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s"}, s, 0);
    chk({tag, "_co"}, co, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] sum;
    int          n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0;
    or_dir = 1'b0; rand_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1;

    // Latency and basic sum
    or_dir = 1'b1;
    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lat_not_yet_valid", out_valid, 0);
    end
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("back_to_idle", in_ready, 1);
    drain();

    // Carry and overflow boundaries
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
    send(16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0, 1);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
    drain();

    // Back-pressure with in_valid held during DONE
    or_dir = 1'b0;
    send(16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1);
    n = 0;
    while (!out_valid && n < 50) begin n++; @(negedge clk); end
    chk("bp_reached_done", out_valid, 1);
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222; ci = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold", {13'b0, s, co, ovf}, {13'b0, 16'h0000, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    or_dir = 1'b1;
    send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1);
    drain();

    // Reset in the middle of RUN
    send(16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("midrun_reset");
    @(posedge clk); #1;
    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1);
    drain();

    // Random operands with random out_ready stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      sum = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      send(ra, rb, rc, sum[15:0], sum[16],
           (ra[15] == rb[15]) && (sum[15] != ra[15]), 1);
    end
    drain();
    rand_mode = 1'b0;

    chk("accept_count", accepts, sends);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Multi-precision adder controller. Adds two 4*N_NIB-bit operands by sequencing one shared 4-bit ripple-carry adder slice (fa4_inst), one nibble per clock, LSB nibble first, carrying between cycles through a carry register. Uses valid/ready handshakes on the operand and result sides. Used where a wide adder is too costly and a few cycles of latency is acceptable.

Parameters:
N_NIB, 4, number of 4-bit nibbles per operand; operand width W = 4*N_NIB; legal range 2..16
CNT_W, 4, width of nibble counter; must satisfy 2**CNT_W >= N_NIB

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands a, b, ci valid
in_ready  output  1  controller can accept operands (high only in IDLE)
a  input  W  operand a (unsigned or two's complement)
b  input  W  operand b
ci  input  1  carry into nibble 0
out_valid  output  1  s, co, ovf valid (high only in DONE)
out_ready  input  1  consumer accepts result
s  output  W  sum
co  output  1  carry out of bit W-1
ovf  output  1  signed overflow flag
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-RUN): state=IDLE; s=0, co=0, ovf=0, out_valid=0, busy=0, carry reg=0, counter=0; in-flight operation discarded. in_ready=1 from the first cycle after reset.
- States: IDLE, RUN, DONE. No other states are reachable.
- IDLE: in_ready=1. On in_valid && in_ready: latch a, b into shift regs A_r, B_r; carry reg <= ci; counter <= 0; s <= 0; go to RUN. Without in_valid, stay in IDLE.
- RUN: slice inputs are A_r[3:0], B_r[3:0], carry reg. Each cycle:
  - A_r, B_r shift right 4.
  - Slice sum nibble enters s at [W-1:W-4]; s shifts right 4, so after N_NIB cycles nibble k sits at s[4k+3:4k].
  - carry reg <= slice carry out; counter increments.
  - When counter = N_NIB-1: co <= slice carry out; ovf <= (A_r[3]==B_r[3]) && (sum nibble[3] != A_r[3]); go to DONE.
  - in_valid, a, b, ci and out_ready are ignored throughout RUN.
- DONE: out_valid=1. s, co and ovf are held stable until out_valid && out_ready; then go to IDLE, and out_valid drops the next cycle. s, co and ovf keep their last values in IDLE.
- Latency: operand accepted at edge t; out_valid is high after edge t+N_NIB. Minimum period between accepts is N_NIB+2 cycles.
- in_ready is 0 in DONE, so a new operand is never accepted in the same cycle a result is consumed. The earliest new accept is the first IDLE cycle.
- in_ready and out_valid are registered-state decodes and have no combinational path from in_valid or out_ready.
- Arithmetic is modulo 2**W; {co,s} = a + b + ci exactly. ovf has two's-complement meaning; co has unsigned meaning; both are always computed.
- out_ready held high before DONE has no effect. in_valid may stay high across many cycles; each IDLE acceptance starts exactly one operation.

Test Plan:
- N_NIB=4, a=0x1234, b=0x4321, ci=0, out_ready=1 -> out_valid exactly 4 cycles after accept; s=0x5555, co=0, ovf=0; back to IDLE 1 cycle later.
- a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1, ovf=0. Also a=0x0FFF, b=0x0000, ci=1 -> s=0x1000, co=0, ovf=0 (carry ripples across all nibble boundaries).
- a=0x7FFF, b=0x0001 -> s=0x8000, co=0, ovf=1. a=0x8000, b=0x8000 -> s=0x0000, co=1, ovf=1.
- Back-pressure: a=0xA5A5, b=0x5A5A, ci=1, out_ready=0 for 6 cycles in DONE, in_valid pulsed with other data -> s=0x0000, co=1, ovf=0 held stable, in_ready=0, no second accept. Raise out_ready -> one handshake, then the pending operand is accepted on the first IDLE cycle.
- Reset mid-RUN: rst=1 at nibble 2 of 0x1111+0x2222 -> next cycle state IDLE, s=0, co=0, ovf=0, out_valid=0, busy=0, in_ready=1. A following 0x0001+0x0001 yields s=0x0002 with no leftover carry.
- Random: 1000 random a, b, ci with random out_ready stalls -> every result equals the golden model {co,s}=a+b+ci and ovf matches the sign rule; no result is lost or duplicated.
